// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
//   state_t : controller states (IDLE, RUN, DONE)
//   OP_MUL  : op encoding for unsigned multiply
//   OP_DIV  : op encoding for unsigned divide
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/muldiv_addsub.sv
// Ripple-carry add/subtract shared by the multiply accumulate step and the
// restoring-division trial subtraction.
// Ports:
//   a, b  [N-1:0] : operands
//   mode          : 0 = a + b, 1 = a - b (a + ~b + 1)
//   sum   [N-1:0] : result
//   cout          : carry out; in subtract mode 1 means a >= b (no borrow)
module muldiv_addsub #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         mode,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N-1:0] b_eff;
    logic [N:0]   carry;

    always_comb begin
        b_eff    = b ^ {N{mode}};
        carry    = '0;
        carry[0] = mode;
        sum      = '0;
        for (int i = 0; i < N; i++) begin
            sum[i]     = a[i] ^ b_eff[i] ^ carry[i];
            carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
        end
        cout = carry[N];
    end

endmodule

// File: rtl/seq_muldiv.sv
// Sequential unsigned multiplier / divider, one operand bit per clock.
// Multiply: shift-and-add, {hi,lo} = a*b.
// Divide:   restoring division, lo = a/b, hi = a%b; b=0 gives lo=all ones,
//           hi=a, dz=1.
// Division is built only when SEQ_MULDIV_DIV_EN is defined; otherwise op=1
// is rejected: done pulses one cycle later with hi=lo=0, dz=1.
// Ports:
//   clk          : clock, rising edge
//   rst_n        : synchronous active-low reset
//   start        : request strobe, accepted in IDLE or DONE
//   op           : 0 = multiply, 1 = divide
//   a, b [W-1:0] : multiplicand/dividend, multiplier/divisor
//   busy         : operation in progress
//   done         : one-cycle completion pulse
//   hi, lo [W-1:0] : result registers
//   dz           : divide-by-zero / rejected-request flag
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// RUN   | W iterations, cnt_q counts W-1 down to 0
// DONE  | one cycle; results transfer to hi/lo, new start may be accepted
module seq_muldiv
    import muldiv_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         dz
);

    localparam int CW = $clog2(W);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  acc_q;    // high half (mul) / partial remainder (div)
    logic [W-1:0]  q_q;      // multiplier shifting out (mul) / quotient shifting in (div)
    logic [W-1:0]  opnd_q;   // a for multiply, b for divide
    logic          ill_q;
    logic          run_req;
    logic          ill_req;

    logic [W:0]    add_x, add_y, add_s;
    logic          add_m, add_co;
    logic [W-1:0]  acc_d, q_d;

`ifdef SEQ_MULDIV_DIV_EN
    logic          op_q;
    logic          dz_q;
`else
    logic          co_unused;
    assign co_unused = add_co;
`endif

    always_comb begin
        state_d = state_q;
        run_req = 1'b0;
        ill_req = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
`ifdef SEQ_MULDIV_DIV_EN
                    run_req = 1'b1;
                    state_d = RUN;
`else
                    if (op == OP_DIV) begin
                        ill_req = 1'b1;
                    end else begin
                        run_req = 1'b1;
                        state_d = RUN;
                    end
`endif
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Multiply: add a when the current multiplier bit is set, then shift the
    // W+1 bit sum right into {acc,q}. Divide: shift the next dividend bit into
    // the remainder and keep the trial difference only if it did not borrow.
    always_comb begin
        add_x = {1'b0, acc_q};
        add_y = q_q[0] ? {1'b0, opnd_q} : '0;
        add_m = 1'b0;
        acc_d = add_s[W:1];
        q_d   = {add_s[0], q_q[W-1:1]};
`ifdef SEQ_MULDIV_DIV_EN
        if (op_q == OP_DIV) begin
            add_x = {acc_q, q_q[W-1]};
            add_y = {1'b0, opnd_q};
            add_m = 1'b1;
            if (add_co) begin
                acc_d = add_s[W-1:0];
                q_d   = {q_q[W-2:0], 1'b1};
            end else begin
                acc_d = add_x[W-1:0];
                q_d   = {q_q[W-2:0], 1'b0};
            end
        end
`endif
    end

    muldiv_addsub #(.N(W + 1)) u_addsub (
        .a    (add_x),
        .b    (add_y),
        .mode (add_m),
        .sum  (add_s),
        .cout (add_co)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            opnd_q  <= '0;
            ill_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            dz      <= 1'b0;
`ifdef SEQ_MULDIV_DIV_EN
            op_q    <= 1'b0;
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ill_q   <= ill_req;
            busy    <= (state_q == RUN);
            done    <= (state_q == DONE) || ill_q;

            if (run_req) begin
                cnt_q <= CW'(W - 1);
                acc_q <= '0;
`ifdef SEQ_MULDIV_DIV_EN
                op_q   <= op;
                dz_q   <= (op == OP_DIV) && (b == '0);
                q_q    <= (op == OP_DIV) ? a : b;
                opnd_q <= (op == OP_DIV) ? b : a;
`else
                q_q    <= b;
                opnd_q <= a;
`endif
            end else if (state_q == RUN) begin
                acc_q <= acc_d;
                q_q   <= q_d;
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end

            if (state_q == DONE) begin
                hi <= acc_q;
                lo <= q_q;
`ifdef SEQ_MULDIV_DIV_EN
                dz <= dz_q;
`else
                dz <= 1'b0;
`endif
            end else if (ill_q) begin
                hi <= '0;
                lo <= '0;
                dz <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_muldiv.sv
module tb_seq_muldiv;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n, start, op;
    logic [W-1:0] a, b, hi, lo;
    logic         busy, done, dz;

    seq_muldiv #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

`ifdef SEQ_MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    // Reference arithmetic for the random sweep.
    function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t            e;
        logic [2*W-1:0]  p;
        e.cyc = 0;
        if (o == 1'b0) begin
            p    = x * y;
            e.hi = p[2*W-1:W];
            e.lo = p[W-1:0];
            e.dz = 1'b0;
        end else if (!DIV_EN) begin
            e.hi = '0;
            e.lo = '0;
            e.dz = 1'b1;
        end else if (y == '0) begin
            e.hi = x;
            e.lo = '1;
            e.dz = 1'b1;
        end else begin
            e.hi = x % y;
            e.lo = x / y;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Monitor: every done pulse is checked against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("hi", hi, e.hi);
                chk("lo", lo, e.lo);
                chk("dz", dz, e.dz);
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Called between a negedge and the next posedge.
    task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        e.hi  = eh;
        e.lo  = el;
        e.dz  = ed;
        e.cyc = cyc + ((o == 1'b0 || DIV_EN) ? W + 2 : 2);
        sb.push_back(e);
    endtask

    task automatic finish_op(input string nm, input int exp_busy);
        int nb = 0;
        int n  = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (busy) nb++;
            n++;
        end while (sb.size() != 0 && n < 100);
        chk({nm, "_pending"}, sb.size(), 0);
        sb.delete();
        if (exp_busy >= 0) chk({nm, "_busy_cycles"}, nb, exp_busy);
    endtask

    task automatic check_cleared(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_hi"},   hi,   0);
        chk({nm, "_lo"},   lo,   0);
        chk({nm, "_dz"},   dz,   0);
    endtask

    typedef struct {
        logic         o;
        logic [W-1:0] x, y, eh, el;
        logic         ed;
    } vec_t;

    initial begin
        vec_t vecs[$];
        int   n;
        int   dc0;
        exp_t e;
        logic o;
        logic [W-1:0] x, y;

        rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        #1;
        check_cleared("reset");
        rst_n = 1'b1;
        @(negedge clk); #1;

        // Directed vectors with hand-computed results.
        vecs.push_back('{1'b0, 8'd12,  8'd11,  8'd0,   8'd132, 1'b0});
        vecs.push_back('{1'b0, 8'd0,   8'd0,   8'd0,   8'd0,   1'b0});
        vecs.push_back('{1'b0, 8'd1,   8'd255, 8'd0,   8'd255, 1'b0});
        vecs.push_back('{1'b0, 8'd200, 8'd3,   8'd2,   8'd88,  1'b0});
`ifdef SEQ_MULDIV_DIV_EN
        vecs.push_back('{1'b1, 8'd13,  8'd3,   8'd1,   8'd4,   1'b0});
        vecs.push_back('{1'b1, 8'd9,   8'd0,   8'd9,   8'd255, 1'b1});
        vecs.push_back('{1'b1, 8'd255, 8'd1,   8'd0,   8'd255, 1'b0});
        vecs.push_back('{1'b1, 8'd7,   8'd200, 8'd7,   8'd0,   1'b0});
        vecs.push_back('{1'b1, 8'd200, 8'd7,   8'd4,   8'd28,  1'b0});
`else
        vecs.push_back('{1'b1, 8'd13,  8'd3,   8'd0,   8'd0,   1'b1});
        vecs.push_back('{1'b1, 8'd9,   8'd0,   8'd0,   8'd0,   1'b1});
`endif
        foreach (vecs[i]) begin
            issue(vecs[i].o, vecs[i].x, vecs[i].y, vecs[i].eh, vecs[i].el, vecs[i].ed);
            finish_op("directed", (vecs[i].o == 1'b0 || DIV_EN) ? W : 0);
            if (i == 0) begin
                repeat (3) @(negedge clk);
                #1;
                chk("hold_lo", lo, 132);
                chk("hold_hi", hi, 0);
            end
        end

        // Back-to-back: new start in the cycle done is high.
        issue(1'b0, 8'd255, 8'd255, 8'd254, 8'd1, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            #1;
            n++;
        end while (!done && n < 100);
        chk("b2b_first_done", done, 1);
        issue(1'b0, 8'd0, 8'd77, 8'd0, 8'd0, 1'b0);
        finish_op("b2b_second", W);

        // start and operand changes during RUN are ignored.
        issue(1'b0, 8'd200, 8'd3, 8'd2, 8'd88, 1'b0);
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
        end
        start = 1'b1; op = 1'b0; a = 8'd1; b = 8'd1;
        @(negedge clk);
        start = 1'b0; a = 8'd5; b = 8'd5;
        finish_op("ignore_start", -1);

        // Reset mid-RUN aborts with no done pulse.
        issue(1'b0, 8'd255, 8'd255, 8'd254, 8'd1, 1'b0);
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
        end
        start = 1'b1; a = 8'd3; b = 8'd3;
        @(negedge clk);
        start = 1'b1;
        rst_n = 1'b0;
        sb.delete();
        dc0 = done_cnt;
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        #1;
        check_cleared("abort");
        repeat (W + 5) @(negedge clk);
        #1;
        chk("abort_no_done", done_cnt - dc0, 0);
        issue(1'b0, 8'd5, 8'd6, 8'd0, 8'd30, 1'b0);
        finish_op("after_abort", W);

        // Random sweep.
        for (int i = 0; i < 1000; i++) begin
            o = 1'($urandom_range(0, 1));
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            if (i % 50 == 0) y = '0;
            e = model(o, x, y);
            issue(o, x, y, e.hi, e.lo, e.dz);
            finish_op("rand", -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
